// File: rtl/aes_word_packer_if.sv
// Word-stream and block-output bundle for aes_word_packer.
// The slave side is the packer; the master side feeds words and drains blocks.
interface aes_word_packer_if #(
    parameter int KEY_LEN  = 128,
    parameter int DATA_LEN = 128,
    parameter int WORD_LEN = 32
);
    logic                word_valid;
    logic                word_ready;
    logic                word_sel;
    logic [WORD_LEN-1:0] word_in;
    logic                data_valid_in;
    logic                data_ready;
    logic [DATA_LEN-1:0] plain_text;
    logic                key_valid_in;
    logic [KEY_LEN-1:0]  cipher_key;
    logic                seq_err;

    modport master (
        output word_valid, word_sel, word_in, data_ready,
        input  word_ready, data_valid_in, plain_text, key_valid_in, cipher_key, seq_err
    );

    modport slave (
        input  word_valid, word_sel, word_in, data_ready,
        output word_ready, data_valid_in, plain_text, key_valid_in, cipher_key, seq_err
    );
endinterface

// File: rtl/aes_word_packer.sv
// Packs 32-bit words into 128-bit AES data blocks and keys; data goes through
// an assembly buffer and an output register, and is held until a key is loaded.
module aes_word_packer #(
    parameter int KEY_LEN  = 128,
    parameter int DATA_LEN = 128,
    parameter int WORD_LEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    aes_word_packer_if.slave bus
);
    localparam int NWORDS = DATA_LEN / WORD_LEN;

    typedef enum logic [1:0] {IDLE, FILL_DATA, FILL_KEY} state_e;

    state_e              state_q;
    logic [1:0]          cnt_q;
    logic                seq_err_q;

    logic [DATA_LEN-1:0] dbuf_q, dbuf_d;
    logic                pend_q, pend_d;
    logic [DATA_LEN-1:0] pt_q, pt_d;
    logic                dv_q, dv_d;

    logic [KEY_LEN-1:0]  kbuf_q, kbuf_d;
    logic [KEY_LEN-1:0]  key_q, key_d;
    logic                key_vld_q, key_vld_d;
    logic                key_loaded_q, key_loaded_d;

    logic                accept;
    logic                sel_match;
    logic [1:0]          slot;
    logic                group_done;
    logic                data_done;
    logic                key_done;
    logic                drain;
    logic                out_free;

    function automatic logic [DATA_LEN-1:0] put_word(input logic [DATA_LEN-1:0] blk,
                                                     input logic [1:0]          idx,
                                                     input logic [WORD_LEN-1:0] w);
        logic [DATA_LEN-1:0] r;
        r = blk;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx == 2'(i)) r[DATA_LEN-1-i*WORD_LEN -: WORD_LEN] = w;
        end
        return r;
    endfunction

    // A pending data block only stalls data words; key words keep flowing so a
    // late key can release the stalled block.
    assign bus.word_ready = ~pend_q | bus.word_sel;

    assign accept     = bus.word_valid & bus.word_ready;
    assign sel_match  = (state_q == FILL_DATA && !bus.word_sel) ||
                        (state_q == FILL_KEY  &&  bus.word_sel);
    assign slot       = sel_match ? cnt_q : 2'd0;
    assign group_done = accept && sel_match && (cnt_q == 2'(NWORDS - 1));
    assign data_done  = group_done && !bus.word_sel;
    assign key_done   = group_done &&  bus.word_sel;
    assign drain      = dv_q & bus.data_ready;
    assign out_free   = ~dv_q | drain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= accept && (state_q != IDLE) && !sel_match;
            if (accept) begin
                if (group_done) begin
                    state_q <= IDLE;
                    cnt_q   <= 2'd0;
                end else begin
                    state_q <= bus.word_sel ? FILL_KEY : FILL_DATA;
                    cnt_q   <= slot + 2'd1;
                end
            end
        end
    end

    always_comb begin
        dbuf_d       = dbuf_q;
        kbuf_d       = kbuf_q;
        pend_d       = pend_q;
        pt_d         = pt_q;
        dv_d         = dv_q & ~drain;
        key_d        = key_q;
        key_vld_d    = key_done;
        key_loaded_d = key_loaded_q | key_done;

        if (accept && !bus.word_sel) dbuf_d = put_word(dbuf_q, slot, bus.word_in);
        if (accept &&  bus.word_sel) kbuf_d = put_word(kbuf_q, slot, bus.word_in);

        // Second stage: the output register takes a block whenever it is empty or
        // emptying this cycle, which keeps back-to-back blocks bubble-free.
        if (pend_q) begin
            if (key_loaded_q && out_free) begin
                pt_d   = dbuf_q;
                dv_d   = 1'b1;
                pend_d = 1'b0;
            end
        end else if (data_done) begin
            if (key_loaded_q && out_free) begin
                pt_d = dbuf_d;
                dv_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end

        if (key_done) key_d = kbuf_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbuf_q       <= '0;
            kbuf_q       <= '0;
            pend_q       <= 1'b0;
            pt_q         <= '0;
            dv_q         <= 1'b0;
            key_q        <= '0;
            key_vld_q    <= 1'b0;
            key_loaded_q <= 1'b0;
        end else begin
            dbuf_q       <= dbuf_d;
            kbuf_q       <= kbuf_d;
            pend_q       <= pend_d;
            pt_q         <= pt_d;
            dv_q         <= dv_d;
            key_q        <= key_d;
            key_vld_q    <= key_vld_d;
            key_loaded_q <= key_loaded_d;
        end
    end

    assign bus.plain_text    = pt_q;
    assign bus.data_valid_in = dv_q;
    assign bus.cipher_key    = key_q;
    assign bus.key_valid_in  = key_vld_q;
    assign bus.seq_err       = seq_err_q;
endmodule
